// File: rtl/snitch_icache_refill_writer.sv
// Refill-to-lookup write buffer for the L1 instruction cache.
// Queues completed line refills, picks a victim way, drains on flush.
module snitch_icache_refill_writer #(
  parameter int unsigned FETCH_AW    = 32,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned LINE_ALIGN  = 4,
  parameter int unsigned COUNT_ALIGN = 5,
  parameter int unsigned SET_COUNT   = 4,
  parameter int unsigned DEPTH       = 2,
  localparam int unsigned SET_ALIGN  =
    (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
  localparam int unsigned TAG_WIDTH  =
    FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_valid_i,
  output logic                   flush_ready_o,
  input  logic [FETCH_AW-1:0]    refill_addr_i,
  input  logic [LINE_WIDTH-1:0]  refill_data_i,
  input  logic                   refill_error_i,
  input  logic                   refill_valid_i,
  output logic                   refill_ready_o,
  output logic [COUNT_ALIGN-1:0] write_addr_o,
  output logic [SET_ALIGN-1:0]   write_set_o,
  output logic [LINE_WIDTH-1:0]  write_data_o,
  output logic [TAG_WIDTH-1:0]   write_tag_o,
  output logic                   write_error_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i,
  output logic                   busy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [COUNT_ALIGN-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    logic [LINE_WIDTH-1:0]  data;
    logic                   err;
  } entry_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  entry_t         r_mem [DEPTH];
  entry_t         w_head;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_cnt;
  logic [SET_ALIGN-1:0] r_victim;
  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_flush_ack;
  logic           w_unused_offset;

  assign w_unused_offset = ^refill_addr_i[LINE_ALIGN-1:0];

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_push  = refill_valid_i && refill_ready_o;
  assign w_pop   = write_valid_o && write_ready_i;
  assign w_head  = r_mem[r_rptr];

  assign refill_ready_o =
    !w_full && (r_state == IDLE) && !flush_valid_i;
  assign write_valid_o = !w_empty;
  assign write_addr_o  = w_head.idx;
  assign write_tag_o   = w_head.tag;
  assign write_data_o  = w_head.data;
  assign write_error_o = w_head.err;
  assign write_set_o   = r_victim;
  assign flush_ready_o = w_flush_ack;
  assign busy_o        = !w_empty || (r_state == DRAIN);

  function automatic logic [PW-1:0] f_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_flush_ack = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (flush_valid_i) begin
          if (w_empty) w_flush_ack = 1'b1;
          else         w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty) begin
          w_flush_ack = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{
          idx:  refill_addr_i[LINE_ALIGN +: COUNT_ALIGN],
          tag:  refill_addr_i[FETCH_AW-1 -: TAG_WIDTH],
          data: refill_data_i,
          err:  refill_error_i
        };
        r_wptr <= f_inc(r_wptr);
      end
      if (w_pop) r_rptr <= f_inc(r_rptr);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Way counter restarts at 0 whenever a flush is acknowledged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_victim <= '0;
    end else if (w_flush_ack) begin
      r_victim <= '0;
    end else if (w_pop) begin
      if (r_victim == SET_ALIGN'(SET_COUNT - 1)) r_victim <= '0;
      else r_victim <= r_victim + 1'b1;
    end
  end

  a_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    write_valid_o && !write_ready_i |=>
      $stable({write_addr_o, write_set_o, write_data_o,
               write_tag_o, write_error_o}));

  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(w_push && w_full));

  a_set_range: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    32'(write_set_o) < SET_COUNT);

  a_flush_hold: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (r_state == DRAIN) |-> flush_valid_i);

endmodule
